// File: rtl/uart_arb_pkg.sv
// uart_arb_pkg: FSM states and default sizes shared by the UART transmit arbiter.
package uart_arb_pkg;
    typedef enum logic [1:0] {IDLE, START, WAIT_ACK, WAIT_DONE} arb_state_t;
    localparam int DEF_DATA_W      = 8;
    localparam int DEF_ACK_TIMEOUT = 16;
    localparam int STATS_W         = 16;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin picker; on a tie the requester not served last wins.
module rr_arb2 (
    input  logic [1:0] valid,
    input  logic       last,
    output logic [1:0] sel
);
    always_comb sel = (valid == 2'b11) ? (last ? 2'b01 : 2'b10) : valid;
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART transmitter between two byte requesters, round-robin.
// Define UART_ARB_STATS_EN to add per-requester accepted-frame counters cnt0_o/cnt1_o.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int ACK_TIMEOUT = DEF_ACK_TIMEOUT
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [1:0]         req_valid_i,
    input  logic [DATA_W-1:0]  req0_data_i,
    input  logic [DATA_W-1:0]  req1_data_i,
    output logic [1:0]         req_ready_o,
    output logic [DATA_W-1:0]  tx_data_o,
    output logic               tx_start_o,
    input  logic               tx_busy_i,
    output logic [1:0]         grant_o,
`ifdef UART_ARB_STATS_EN
    output logic [STATS_W-1:0] cnt0_o,
    output logic [STATS_W-1:0] cnt1_o,
`endif
    output logic               err_o
);
    localparam int TW = $clog2(ACK_TIMEOUT + 1);

    arb_state_t        r_state, w_next;
    logic [TW-1:0]     r_tmo;
    logic              r_last, r_err, w_timeout;
    logic [1:0]        w_sel, w_acc, r_grant;
    logic [DATA_W-1:0] r_data;

    rr_arb2 u_rr (.valid(req_valid_i), .last(r_last), .sel(w_sel));

    always_comb begin
        req_ready_o = (r_state == IDLE && !tx_busy_i) ? w_sel : 2'b00;
        w_acc       = req_valid_i & req_ready_o;
        w_timeout   = r_state == WAIT_ACK && !tx_busy_i && r_tmo == TW'(ACK_TIMEOUT - 1);
        w_next      = r_state;
        case (r_state)
            IDLE:      w_next = |w_acc ? START : IDLE;
            START:     w_next = WAIT_ACK;
            WAIT_ACK:  w_next = tx_busy_i ? WAIT_DONE : (w_timeout ? IDLE : WAIT_ACK);
            WAIT_DONE: w_next = tx_busy_i ? WAIT_DONE : IDLE;
            default:   w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // r_last = 1 means requester 1 was served last, so requester 0 wins the first tie
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_data  <= '0;
            r_grant <= '0;
            r_err   <= 1'b0;
            r_tmo   <= '0;
            r_last  <= 1'b1;
        end else begin
            r_err <= w_timeout;
            r_tmo <= (r_state == WAIT_ACK) ? r_tmo + 1'b1 : '0;
            if (|w_acc) begin
                r_data  <= w_acc[1] ? req1_data_i : req0_data_i;
                r_grant <= w_acc;
                r_last  <= w_acc[1];
            end else if (w_next == IDLE) begin
                r_grant <= '0;
            end
        end
    end

    assign tx_data_o  = r_data;
    assign tx_start_o = r_state == START;
    assign grant_o    = r_grant;
    assign err_o      = r_err;

`ifdef UART_ARB_STATS_EN
    logic [STATS_W-1:0] r_cnt0, r_cnt1;
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_cnt0 <= '0;
            r_cnt1 <= '0;
        end else begin
            if (w_acc[0]) r_cnt0 <= r_cnt0 + 1'b1;
            if (w_acc[1]) r_cnt1 <= r_cnt1 + 1'b1;
        end
    end
    assign cnt0_o = r_cnt0;
    assign cnt1_o = r_cnt1;
`endif
endmodule
